// File: rtl/ibf_pkg.sv
// Shared helpers and types for the inverse-butterfly permutation pipeline.
package ibf_pkg;

  typedef enum logic {IDLE, DRAIN} commit_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Width of the stage-select address; never narrower than one bit.
  function automatic int cfg_addr_w(input int dw);
    int s;
    s = clog2(dw);
    return (s > 1) ? clog2(s) : 1;
  endfunction

  function automatic int popcount(input logic [31:0] m);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(m[i]);
    return c;
  endfunction

endpackage

// File: rtl/ibf_stage_core.sv
// One inverse-butterfly stage: pairwise swaps at distance 2^STAGE_ORDER,
// optionally followed by an enable-gated data/valid register.
module ibf_stage_core #(
  parameter int DATA_WIDTH  = 32,
  parameter int STAGE_ORDER = 0,
  parameter bit IS_PIPED    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DATA_WIDTH/2-1:0] cfg,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    valid_in,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    valid_out,
  output logic                    busy
);
  localparam int SHIFT   = 1 << STAGE_ORDER;
  localparam int E       = 2 * SHIFT;
  localparam int REGIONS = DATA_WIDTH / E;

  logic [DATA_WIDTH-1:0] perm;

  genvar gi, gj;
  for (gi = 0; gi < REGIONS; gi++) begin : g_region
    for (gj = 0; gj < SHIFT; gj++) begin : g_elem
      localparam int LO = E * gi + gj;
      localparam int HI = LO + SHIFT;
      localparam int CB = gi * SHIFT + gj;
      assign perm[LO] = cfg[CB] ? din[HI] : din[LO];
      assign perm[HI] = cfg[CB] ? din[LO] : din[HI];
    end
  end

  if (IS_PIPED) begin : g_reg
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  valid_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        data_reg  <= '0;
        valid_reg <= 1'b0;
      end else if (en) begin
        data_reg  <= perm;
        valid_reg <= valid_in;
      end
    end
    assign dout      = data_reg;
    assign valid_out = valid_reg;
    assign busy      = valid_reg;
  end else begin : g_comb
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst, en};
    assign dout        = perm;
    assign valid_out   = valid_in;
    assign busy        = 1'b0;
  end

endmodule

// File: rtl/ibf_bf_network_pipe.sv
// Full inverse-butterfly permutation pipeline with valid/ready flow control
// and shadow/active per-stage configuration committed only once drained.
module ibf_bf_network_pipe
  import ibf_pkg::*;
#(
  parameter int                           DATA_WIDTH = 32,
  parameter logic [clog2(DATA_WIDTH)-1:0] PIPE_MASK  = '1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_wr_en,
  input  logic [cfg_addr_w(DATA_WIDTH)-1:0]   cfg_wr_addr,
  input  logic [DATA_WIDTH/2-1:0]             cfg_wr_data,
  input  logic                                cfg_commit,
  output logic                                cfg_pending,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               din,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               dout
);
  localparam int STAGES = clog2(DATA_WIDTH);
  localparam int CFG_W  = DATA_WIDTH / 2;
  localparam int AW     = cfg_addr_w(DATA_WIDTH);
  localparam int LAT    = popcount(32'(PIPE_MASK));

  commit_state_t     state_reg;
  logic              pending_reg;
  logic              adv;
  logic              entry_valid;
  logic              pipe_empty;
  logic              copy_now;
  logic [STAGES-1:0] stage_busy;

  // Entry valid does not depend on adv, so a fully combinational build has no loop.
  assign entry_valid = in_valid & ~rst & ~pending_reg;
  assign adv         = ~out_valid | out_ready;
  assign in_ready    = ~rst & ~pending_reg & ((LAT == 0) ? out_ready : adv);
  assign pipe_empty  = ~(|stage_busy) & ~out_valid;
  assign copy_now    = (state_reg == DRAIN) & pipe_empty;
  assign cfg_pending = pending_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      pending_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (cfg_commit) begin
          state_reg   <= DRAIN;
          pending_reg <= 1'b1;
        end
        DRAIN: if (pipe_empty) begin
          state_reg   <= IDLE;
          pending_reg <= 1'b0;
        end
        default: begin
          state_reg   <= IDLE;
          pending_reg <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [DATA_WIDTH-1:0] d_in, d_out;
    logic                  v_in, v_out, busy, wr_hit;
    logic [CFG_W-1:0]      shadow_reg, active_reg;

    if (gi == 0) begin : g_head
      assign d_in = din;
      assign v_in = entry_valid;
    end else begin : g_link
      assign d_in = g_stage[gi-1].d_out;
      assign v_in = g_stage[gi-1].v_out;
    end

    assign wr_hit = cfg_wr_en && (cfg_wr_addr == AW'(gi));

    // A write landing in the copy cycle is forwarded so the new word goes active.
    always_ff @(posedge clk) begin
      if (rst) begin
        shadow_reg <= '0;
        active_reg <= '0;
      end else begin
        if (wr_hit)   shadow_reg <= cfg_wr_data;
        if (copy_now) active_reg <= wr_hit ? cfg_wr_data : shadow_reg;
      end
    end

    ibf_stage_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGE_ORDER(gi),
      .IS_PIPED   (PIPE_MASK[gi])
    ) u_core (
      .clk      (clk),
      .rst      (rst),
      .en       (adv),
      .cfg      (active_reg),
      .din      (d_in),
      .valid_in (v_in),
      .dout     (d_out),
      .valid_out(v_out),
      .busy     (busy)
    );

    assign stage_busy[gi] = busy;
  end

  assign dout      = g_stage[STAGES-1].d_out;
  assign out_valid = g_stage[STAGES-1].v_out;

endmodule

// File: tb/tb_ibf_bf_network_pipe.sv
// Self-checking bench: scoreboard model of the permutation network plus
// directed checks on latency, commit draining and a fully combinational build.
module tb_ibf_bf_network_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr_en = 1'b0;
  logic [2:0]  cfg_wr_addr = '0;
  logic [15:0] cfg_wr_data = '0;
  logic        cfg_commit = 1'b0;
  logic        cfg_pending;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] din = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] dout;

  logic        z_wr_en = 1'b0;
  logic [2:0]  z_wr_addr = '0;
  logic [15:0] z_wr_data = '0;
  logic        z_commit = 1'b0;
  logic        z_pending;
  logic        z_in_valid = 1'b0;
  logic        z_in_ready;
  logic [31:0] z_din = '0;
  logic        z_out_valid;
  logic        z_out_ready = 1'b1;
  logic [31:0] z_dout;

  always #5 clk = ~clk;

  ibf_bf_network_pipe #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_commit(cfg_commit), .cfg_pending(cfg_pending),
    .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
  );

  ibf_bf_network_pipe #(.DATA_WIDTH(32), .PIPE_MASK(5'b00000)) dut0 (
    .clk(clk), .rst(rst), .cfg_wr_en(z_wr_en), .cfg_wr_addr(z_wr_addr),
    .cfg_wr_data(z_wr_data), .cfg_commit(z_commit), .cfg_pending(z_pending),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .din(z_din),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .dout(z_dout)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic void chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endfunction

  function automatic void fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", name);
  endfunction

  // Reference permutation: each bit p with bit s clear pairs with p+2^s.
  function automatic logic [31:0] perm(input logic [31:0] d, input logic [4:0][15:0] c);
    logic [31:0] x, y;
    int sh, idx;
    x = d;
    for (int s = 0; s < 5; s++) begin
      sh = 1 << s;
      y  = x;
      for (int p = 0; p < 32; p++) begin
        if ((p & sh) == 0) begin
          idx = (p >> (s + 1)) * sh + (p % sh);
          if (c[s][idx]) begin
            y[p]      = x[p + sh];
            y[p + sh] = x[p];
          end
        end
      end
      x = y;
    end
    return x;
  endfunction

  logic [4:0][15:0] m_shadow, m_active;
  bit               m_pending;
  logic [31:0]      q[$];
  bit               prev_stall;
  logic [31:0]      prev_dout;

  // Scoreboard: checks handshake/outputs, then advances the model across the coming edge.
  always @(negedge clk) begin
    logic             exp_rdy;
    bit               empty;
    logic [31:0]      e;
    logic [4:0][15:0] nxt;
    if (rst) begin
      chk1("in_ready_in_reset", in_ready, 1'b0);
      q.delete();
      m_pending  = 0;
      m_shadow   = '0;
      m_active   = '0;
      prev_stall = 0;
    end else begin
      chk1("cfg_pending", cfg_pending, m_pending);
      exp_rdy = !m_pending && (!out_valid || out_ready);
      chk1("in_ready", in_ready, exp_rdy);
      if (prev_stall) begin
        chk1("stall_out_valid", out_valid, 1'b1);
        chk("stall_dout", dout, prev_dout);
      end
      if (out_valid && q.size() == 0) fail_timeout("spurious_out_valid");
      empty = (q.size() == 0);
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("dout", dout, e);
        n_out++;
      end
      if (in_valid && exp_rdy) q.push_back(perm(din, m_active));
      if (m_pending && empty) begin
        nxt = m_shadow;
        if (cfg_wr_en && cfg_wr_addr < 3'd5) nxt[cfg_wr_addr] = cfg_wr_data;
        m_active  = nxt;
        m_pending = 0;
      end else if (!m_pending && cfg_commit) begin
        m_pending = 1;
      end
      if (cfg_wr_en && cfg_wr_addr < 3'd5) m_shadow[cfg_wr_addr] = cfg_wr_data;
      prev_stall = out_valid && !out_ready;
      prev_dout  = dout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic commit(input string name);
    bit done;
    done = 0;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!cfg_pending) begin done = 1; break; end
    end
    if (!done) fail_timeout(name);
    tick();
  endtask

  task automatic send(input string name, input logic [31:0] d);
    bit done;
    done = 0;
    in_valid = 1'b1; din = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin done = 1; break; end
    end
    if (!done) fail_timeout(name);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv(input string name, input logic [31:0] exp);
    bit done;
    done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin done = 1; break; end
    end
    if (!done) fail_timeout(name);
    else chk(name, dout, exp);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0][15:0] pc;
    int start, n;
    bit done;

    pc = '0;
    chk("model_identity", perm(32'h12345678, pc), 32'h12345678);
    pc[0] = 16'hFFFF;
    chk("model_stage0", perm(32'h55555555, pc), 32'hAAAAAAAA);
    pc = '0; pc[4] = 16'hFFFF;
    chk("model_stage4", perm(32'h0000FFFF, pc), 32'hFFFF0000);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_dout", dout, 32'h0);
    chk1("rst_cfg_pending", cfg_pending, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: identity and exact latency of five cycles
    in_valid = 1'b1; din = 32'h12345678;
    @(negedge clk);
    chk1("t1_accept", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c < 5) chk1("t1_no_early_valid", out_valid, 1'b0);
      else begin
        chk1("t1_valid_at_5", out_valid, 1'b1);
        chk("t1_dout", dout, 32'h12345678);
      end
    end
    tick();

    // 2: single-stage swaps
    cfg_write(3'd0, 16'hFFFF);
    commit("t2_commit_a");
    send("t2_send_a", 32'h55555555);
    recv("t2_stage0", 32'hAAAAAAAA);
    cfg_write(3'd0, 16'h0000);
    cfg_write(3'd4, 16'hFFFF);
    commit("t2_commit_b");
    send("t2_send_b", 32'h0000FFFF);
    recv("t2_stage4", 32'hFFFF0000);

    // 3: random config, 20 back-to-back beats with random back-pressure
    for (int s = 0; s < 5; s++) cfg_write(3'(s), 16'($urandom));
    commit("t3_commit");
    start = n_out;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          in_valid = 1'b1; din = $urandom;
          done = 0;
          for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin done = 1; break; end
          end
          if (!done) fail_timeout("t3_accept");
          tick();
        end
        in_valid = 1'b0;
      end
      begin
        repeat (150) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    tick();
    chk("t3_beats_out", 32'(n_out - start), 32'd20);

    // 4: commit with three beats in flight
    cfg_write(3'd0, 16'hFFFF);
    for (int s = 1; s < 5; s++) cfg_write(3'(s), 16'h0000);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; din = $urandom;
      @(negedge clk);
      chk1("t4_accept", in_ready, 1'b1);
      tick();
    end
    in_valid = 1'b0; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0; in_valid = 1'b1; din = 32'h55555555;
    @(negedge clk);
    chk1("t4_refuse", in_ready, 1'b0);
    chk1("t4_pending", cfg_pending, 1'b1);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (!cfg_pending) break;
      n++;
      @(negedge clk);
    end
    chk("t4_pending_cycles", 32'(n), 32'd5);
    tick();
    in_valid = 1'b0;
    recv("t4_new_cfg", 32'hAAAAAAAA);

    // 5: out-of-range write ignored; write in the copy cycle goes active
    for (int s = 0; s < 5; s++) cfg_write(3'(s), 16'h0000);
    commit("t5_commit_id");
    cfg_write(3'd7, 16'hFFFF);
    commit("t5_commit_bad");
    send("t5_send_bad", 32'h12345678);
    recv("t5_addr7_ignored", 32'h12345678);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    cfg_wr_en = 1'b1; cfg_wr_addr = 3'd0; cfg_wr_data = 16'hFFFF;
    @(negedge clk);
    chk1("t5_copy_cycle_pending", cfg_pending, 1'b1);
    tick();
    cfg_wr_en = 1'b0;
    @(negedge clk);
    chk1("t5_copy_done", cfg_pending, 1'b0);
    tick();
    send("t5_send_wf", 32'h55555555);
    recv("t5_write_first", 32'hAAAAAAAA);

    // 6: fully combinational build
    z_wr_en = 1'b1; z_wr_addr = 3'd0; z_wr_data = 16'hFFFF;
    tick();
    z_wr_en = 1'b0; z_commit = 1'b1;
    tick();
    z_commit = 1'b0; z_in_valid = 1'b1; z_din = 32'h55555555;
    @(negedge clk);
    chk1("t6_comb_pending", z_pending, 1'b1);
    chk1("t6_comb_refuse", z_in_ready, 1'b0);
    tick();
    @(negedge clk);
    chk1("t6_comb_valid", z_out_valid, 1'b1);
    chk1("t6_comb_ready", z_in_ready, 1'b1);
    chk("t6_comb_dout", z_dout, 32'hAAAAAAAA);
    tick();
    z_out_ready = 1'b0;
    @(negedge clk);
    chk1("t6_comb_backpressure", z_in_ready, 1'b0);
    tick();
    z_in_valid = 1'b0; z_out_ready = 1'b1;

    // 6b: reset mid-stream discards beats and restores identity
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; din = $urandom;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk1("t6_rst_out_valid", out_valid, 1'b0);
    chk1("t6_rst_pending", cfg_pending, 1'b0);
    tick();
    out_ready = 1'b1;
    send("t6_send_post_rst", 32'h55555555);
    recv("t6_rst_identity", 32'h55555555);
    z_in_valid = 1'b1; z_din = 32'h55555555;
    @(negedge clk);
    chk("t6_comb_rst_identity", z_dout, 32'h55555555);
    tick();
    z_in_valid = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
